mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Parametrised memory-access engine between the datapath's MAR/MDR path and the memory bus.
//  Accepts one load/store request per handshake and runs the bus strobe until mem_resp or timeout.
//  Handles byte lanes for any power-of-two word width; zero- or sign-extends byte loads.
//  Rejects misaligned word accesses without a bus cycle. Successor to the fixed 16-bit MAR/MDR path.
// PARAMETERS
//  WORD_WIDTH      16   data width in bits; multiple of 8, power of two; LANES = WORD_WIDTH/8
//  ADDR_WIDTH      16   byte-address width
//  TIMEOUT_CYCLES  255  max strobe cycles without mem_resp; 0 disables the timeout
// PORTS
//  clk             in   1            rising-edge clock
//  rst             in   1            asynchronous reset, active-high
//  req_valid       in   1            request present
//  req_ready       out  1            unit can accept; high only in IDLE
//  req_write       in   1            1 = store, 0 = load
//  req_size        in   1            0 = word, 1 = byte
//  req_signed      in   1            byte load: 1 = sign-extend, 0 = zero-extend
//  req_addr        in   ADDR_WIDTH   byte address
//  req_wdata       in   WORD_WIDTH   store data; byte store uses [7:0]
//  resp_valid      out  1            one-cycle pulse: request complete
//  resp_rdata      out  WORD_WIDTH   load result; 0 for stores and errors
//  resp_err        out  2            lc3b_mem_err: 00 OK, 01 MISALIGN, 10 TIMEOUT
//  mem_address     out  ADDR_WIDTH   bus address: latched req_addr, unmodified
//  mem_wdata       out  WORD_WIDTH   bus write data
//  mem_read        out  1            read strobe
//  mem_write       out  1            write strobe
//  mem_byte_enable out  LANES        per-lane write enable
//  mem_rdata       in   WORD_WIDTH   bus read data; valid with mem_resp
//  mem_resp        in   1            bus completion
// BEHAVIOUR
//  Reset, async: state IDLE. req_ready=1; every other output 0, including strobes, enables and counter.
//  Accept on req_valid & req_ready: latch all req_* fields. Next state depends on alignment.
//  Alignment: off = addr[$clog2(LANES)-1:0]. A word request with off!=0 is misaligned.
//  Misaligned word: go to DONE, resp_err=MISALIGN, no strobe ever asserted.
//  Otherwise go to ACCESS.
//  States: IDLE -> ACCESS | DONE; ACCESS -> DONE; DONE -> IDLE. A request that cannot be accepted is never dropped.
//  ACCESS:
//   - exactly one of mem_read/mem_write held high every cycle; mem_address/mem_wdata/mem_byte_enable stable.
//   - Word store: byte_enable all ones, mem_wdata = wdata.
//   - Byte store: wdata[7:0] replicated to every lane; byte_enable one-hot at bit off.
//   - Loads: byte_enable = 0.
//  mem_resp in ACCESS: capture, go to DONE; strobes low from the next cycle.
//  Load data:
//   - word: rdata = mem_rdata.
//   - byte: b = mem_rdata[8*off +: 8], extended per req_signed.
//  Timeout counter:
//   - cleared on entering ACCESS; counts each ACCESS cycle without mem_resp.
//   - at TIMEOUT_CYCLES: go to DONE, resp_err=TIMEOUT, rdata=0.
//   - mem_resp in the expiry cycle wins (OK).
//  DONE: resp_valid=1 for exactly one cycle, req_ready=0; resp_* hold until the next response.
//  Latency, bus responding in k>=1 strobe cycles:
//   - accept at cycle 0; strobes in cycles 1..k; resp_valid in cycle k+1.
//   - next accept possible at cycle k+2. Misaligned: resp_valid at cycle 1.
//  mem_resp outside ACCESS is ignored. req_* changes after acceptance have no effect.
//  rst mid-ACCESS: strobes drop immediately (async); no resp_valid is produced for the aborted request.
// STRUCTURE
//  lc3b_types gains: typedef enum logic[1:0] lc3b_mem_err {MEM_OK, MEM_MISALIGN, MEM_TIMEOUT}.
//  State enum and timeout counter are local. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
//  One sub-module: byte_lane_extract #(WORD_WIDTH) (data, lane, is_signed -> word), purely combinational.
// TESTING
//  1. Word load addr 0x0010, mem_resp after 3 cycles with 0xBEEF -> mem_read high 3 cycles; resp_valid at cycle 4, rdata 0xBEEF, err 00.
//  2. Byte load addr 0x0011, rdata 0x80AA, signed=1 -> rdata 0xFF80; same with signed=0 -> 0x0080.
//  3. Byte store addr 0x0011, wdata 0x1234 -> mem_wdata 0x3434, byte_enable 2'b10, mem_write until mem_resp; resp rdata 0.
//  4. Word store addr 0x0013 -> no strobe; resp_valid at cycle 1, err 01.
//  5. TIMEOUT_CYCLES=4, no mem_resp -> 4 strobe cycles, then resp err 10. Repeat with mem_resp in the 4th cycle -> err 00.
//  6. Reset asserted in the 2nd ACCESS cycle -> strobes 0 immediately, req_ready=1 after release, no resp_valid; WORD_WIDTH=32 rerun of tests 2/3 using lane 3.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory-access engine.
// Error codes returned with every response, plus a width helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_OK       = 2'b00,
    MEM_MISALIGN = 2'b01,
    MEM_TIMEOUT  = 2'b10
  } lc3b_mem_err;

  // $clog2 that never returns less than 1, for sizing index/counter vectors
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_extract.sv
// Selects one byte lane of a bus word and zero- or sign-extends it to the full word.
// Purely combinational.
module byte_lane_extract
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  localparam int unsigned LANE_W = clog2_min1(WORD_WIDTH / 8)
) (
  input  logic [WORD_WIDTH-1:0] data,
  input  logic [LANE_W-1:0]     lane,
  input  logic                  is_signed,
  output logic [WORD_WIDTH-1:0] word
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = 8'(data >> {lane, 3'b000});
    if (is_signed) begin
      word = WORD_WIDTH'($signed(lane_byte));
    end else begin
      word = WORD_WIDTH'(lane_byte);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine between the MAR/MDR datapath and the memory bus: one request per
// handshake, byte-lane steering, misalignment rejection and a bus timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned LANES         = WORD_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LANES-1:0]      mem_byte_enable,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int unsigned OFF_W   = clog2_min1(LANES);
  localparam int unsigned CNT_W   = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   lat_size, lat_size_nxt;
  logic                   lat_signed, lat_signed_nxt;
  logic                   req_ready_nxt;
  logic                   mem_read_nxt, mem_write_nxt;
  logic [LANES-1:0]       be_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [WORD_WIDTH-1:0]  wdata_nxt;
  logic [WORD_WIDTH-1:0]  rdata_nxt;
  logic [WORD_WIDTH-1:0]  ext_word;
  logic                   resp_valid_nxt;
  lc3b_mem_err            err_nxt;
  logic [OFF_W-1:0]       req_off, lat_off;

  // Byte offset within the word; a single-lane bus has no offset bits
  assign req_off = (LANES > 1) ? OFF_W'(req_addr) : '0;
  assign lat_off = (LANES > 1) ? OFF_W'(mem_address) : '0;

  byte_lane_extract #(.WORD_WIDTH(WORD_WIDTH)) u_extract (
    .data      (mem_rdata),
    .lane      (lat_off),
    .is_signed (lat_signed),
    .word      (ext_word)
  );

  // State and registered outputs; reset drops the strobes immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      lat_size        <= 1'b0;
      lat_signed      <= 1'b0;
      req_ready       <= 1'b1;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= MEM_OK;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      lat_size        <= lat_size_nxt;
      lat_signed      <= lat_signed_nxt;
      req_ready       <= req_ready_nxt;
      mem_read        <= mem_read_nxt;
      mem_write       <= mem_write_nxt;
      mem_byte_enable <= be_nxt;
      mem_address     <= addr_nxt;
      mem_wdata       <= wdata_nxt;
      resp_valid      <= resp_valid_nxt;
      resp_rdata      <= rdata_nxt;
      resp_err        <= err_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    lat_size_nxt   = lat_size;
    lat_signed_nxt = lat_signed;
    mem_read_nxt   = mem_read;
    mem_write_nxt  = mem_write;
    be_nxt         = mem_byte_enable;
    addr_nxt       = mem_address;
    wdata_nxt      = mem_wdata;
    resp_valid_nxt = 1'b0;
    rdata_nxt      = resp_rdata;
    err_nxt        = lc3b_mem_err'(resp_err);

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          lat_size_nxt   = req_size;
          lat_signed_nxt = req_signed;
          addr_nxt       = req_addr;
          if (!req_size && (req_off != '0)) begin
            // Misaligned word: answer straight away, never touch the bus
            state_nxt      = ST_DONE;
            resp_valid_nxt = 1'b1;
            err_nxt        = MEM_MISALIGN;
            rdata_nxt      = '0;
          end else begin
            state_nxt     = ST_ACCESS;
            cnt_nxt       = '0;
            mem_read_nxt  = !req_write;
            mem_write_nxt = req_write;
            if (!req_write) begin
              be_nxt    = '0;
              wdata_nxt = '0;
            end else if (req_size) begin
              be_nxt    = LANES'(1) << req_off;
              wdata_nxt = {LANES{req_wdata[7:0]}};
            end else begin
              be_nxt    = '1;
              wdata_nxt = req_wdata;
            end
          end
        end
      end

      ST_ACCESS: begin
        if (mem_resp) begin
          // A response in the expiry cycle still counts as success
          state_nxt      = ST_DONE;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
          be_nxt         = '0;
          resp_valid_nxt = 1'b1;
          err_nxt        = MEM_OK;
          if (!mem_read) begin
            rdata_nxt = '0;
          end else if (lat_size) begin
            rdata_nxt = ext_word;
          end else begin
            rdata_nxt = mem_rdata;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST))) begin
          state_nxt      = ST_DONE;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
          be_nxt         = '0;
          resp_valid_nxt = 1'b1;
          err_nxt        = MEM_TIMEOUT;
          rdata_nxt      = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    req_ready_nxt = (state_nxt == ST_IDLE);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 16-bit instance with a 4-cycle timeout
// and a 32-bit instance with the default timeout, driven by a small bus responder.
module tb_mem_access_unit;

  logic clk;
  logic rst;

  logic        rv[2], rw[2], rs[2], rsg[2], mresp[2];
  logic [15:0] raddr[2];
  logic [31:0] rwd[2], mrd[2];

  logic        a_ready, a_rvalid, a_read, a_write;
  logic [15:0] a_rdata, a_addr, a_wdata;
  logic [1:0]  a_err, a_be;
  logic        b_ready, b_rvalid, b_read, b_write;
  logic [31:0] b_rdata, b_wdata;
  logic [15:0] b_addr;
  logic [1:0]  b_err;
  logic [3:0]  b_be;

  logic        o_ready[2], o_rvalid[2], o_read[2], o_write[2];
  logic [31:0] o_rdata[2], o_wdata[2];
  logic [15:0] o_addr[2];
  logic [1:0]  o_err[2];
  logic [3:0]  o_be[2];

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) u_dut16 (
    .clk (clk), .rst (rst),
    .req_valid (rv[0]), .req_ready (a_ready), .req_write (rw[0]), .req_size (rs[0]),
    .req_signed (rsg[0]), .req_addr (raddr[0]), .req_wdata (rwd[0][15:0]),
    .resp_valid (a_rvalid), .resp_rdata (a_rdata), .resp_err (a_err),
    .mem_address (a_addr), .mem_wdata (a_wdata), .mem_read (a_read), .mem_write (a_write),
    .mem_byte_enable (a_be), .mem_rdata (mrd[0][15:0]), .mem_resp (mresp[0])
  );

  mem_access_unit #(.WORD_WIDTH(32), .ADDR_WIDTH(16)) u_dut32 (
    .clk (clk), .rst (rst),
    .req_valid (rv[1]), .req_ready (b_ready), .req_write (rw[1]), .req_size (rs[1]),
    .req_signed (rsg[1]), .req_addr (raddr[1]), .req_wdata (rwd[1]),
    .resp_valid (b_rvalid), .resp_rdata (b_rdata), .resp_err (b_err),
    .mem_address (b_addr), .mem_wdata (b_wdata), .mem_read (b_read), .mem_write (b_write),
    .mem_byte_enable (b_be), .mem_rdata (mrd[1]), .mem_resp (mresp[1])
  );

  always_comb begin
    o_ready[0]  = a_ready;           o_ready[1]  = b_ready;
    o_rvalid[0] = a_rvalid;          o_rvalid[1] = b_rvalid;
    o_read[0]   = a_read;            o_read[1]   = b_read;
    o_write[0]  = a_write;           o_write[1]  = b_write;
    o_rdata[0]  = {16'h0, a_rdata};  o_rdata[1]  = b_rdata;
    o_wdata[0]  = {16'h0, a_wdata};  o_wdata[1]  = b_wdata;
    o_addr[0]   = a_addr;            o_addr[1]   = b_addr;
    o_err[0]    = a_err;             o_err[1]    = b_err;
    o_be[0]     = {2'b00, a_be};     o_be[1]     = b_be;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and act as the bus: raise mem_resp on the k-th strobe cycle (k=0: never)
  task automatic txn(input int idx, input logic wr, input logic sz, input logic sg,
                     input logic [15:0] addr, input logic [31:0] wd, input int k,
                     input logic [31:0] rd, output int strobes, output int rcycle,
                     output logic [31:0] rdata, output logic [1:0] err,
                     output logic [31:0] bwd, output logic [3:0] bbe,
                     output logic [15:0] baddr, output logic stable, output logic bad_strobe);
    @(negedge clk);
    check("ready_before_req", 32'(o_ready[idx]), 32'd1);
    rw[idx] = wr; rs[idx] = sz; rsg[idx] = sg; raddr[idx] = addr; rwd[idx] = wd;
    rv[idx] = 1'b1;
    @(posedge clk); #1;
    rv[idx] = 1'b0; rw[idx] = ~wr; rs[idx] = ~sz; rsg[idx] = ~sg;
    raddr[idx] = ~addr; rwd[idx] = ~wd;
    strobes = 0; rcycle = -1; stable = 1'b1; bad_strobe = 1'b0;
    rdata = '0; err = '0; bwd = '0; bbe = '0; baddr = '0;
    for (int c = 1; c <= 20; c++) begin
      if (o_read[idx] || o_write[idx]) begin
        if ((o_read[idx] && o_write[idx]) || (o_write[idx] != wr)) bad_strobe = 1'b1;
        if (strobes == 0) begin
          bwd = o_wdata[idx]; bbe = o_be[idx]; baddr = o_addr[idx];
        end else if (bwd != o_wdata[idx] || bbe != o_be[idx] || baddr != o_addr[idx]) begin
          stable = 1'b0;
        end
        strobes++;
        if (strobes == k) begin
          mresp[idx] = 1'b1;
          mrd[idx]   = rd;
        end
      end
      if (o_rvalid[idx]) begin
        rcycle = c;
        rdata  = o_rdata[idx];
        err    = o_err[idx];
        break;
      end
      @(posedge clk); #1;
      mresp[idx] = 1'b0;
      mrd[idx]   = 32'h5A5A_5A5A;
    end
  endtask

  task automatic run(input string tag, input int idx, input logic wr, input logic sz,
                     input logic sg, input logic [15:0] addr, input logic [31:0] wd,
                     input int k, input logic [31:0] rd, input int exp_strobes,
                     input int exp_rc, input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                     input logic [31:0] exp_wd, input logic [3:0] exp_be);
    int strobes, rcycle;
    logic [31:0] rdata, bwd;
    logic [1:0]  err;
    logic [3:0]  bbe;
    logic [15:0] baddr;
    logic        stable, bad_strobe;
    txn(idx, wr, sz, sg, addr, wd, k, rd, strobes, rcycle, rdata, err, bwd, bbe, baddr,
        stable, bad_strobe);
    check({tag, ".strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
    check({tag, ".resp_cycle"}, 32'(rcycle), 32'(exp_rc));
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    if (exp_strobes > 0) begin
      check({tag, ".mem_address"}, 32'(baddr), 32'(addr));
      check({tag, ".byte_enable"}, 32'(bbe), 32'(exp_be));
      if (wr) check({tag, ".mem_wdata"}, bwd, exp_wd);
      check({tag, ".bus_stable"}, 32'(stable), 32'd1);
      check({tag, ".strobe_kind"}, 32'(bad_strobe), 32'd0);
    end
    @(posedge clk); #1;
    check({tag, ".resp_one_cycle"}, 32'(o_rvalid[idx]), 32'd0);
    check({tag, ".ready_after"}, 32'(o_ready[idx]), 32'd1);
    check({tag, ".rdata_hold"}, o_rdata[idx], exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; rs[i] = 1'b0; rsg[i] = 1'b0; mresp[i] = 1'b0;
      raddr[i] = '0; rwd[i] = '0; mrd[i] = 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("reset.req_ready", 32'(o_ready[i]), 32'd1);
      check("reset.strobes", 32'({o_read[i], o_write[i]}), 32'd0);
      check("reset.byte_enable", 32'(o_be[i]), 32'd0);
      check("reset.resp_valid", 32'(o_rvalid[i]), 32'd0);
      check("reset.resp_rdata", o_rdata[i], 32'd0);
      check("reset.resp_err", 32'(o_err[i]), 32'd0);
      check("reset.mem_address", 32'(o_addr[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    //  tag           idx wr sz sg addr      wdata         k  mem_rdata      strb rc rdata          err  exp_wd         exp_be
    run("wload",       0, 0, 0, 0, 16'h0010, 32'h0,        3, 32'h0000_BEEF, 3,  4, 32'h0000_BEEF, 0,   32'h0,         4'b0000);
    run("bload_s",     0, 0, 1, 1, 16'h0011, 32'h0,        1, 32'h0000_80AA, 1,  2, 32'h0000_FF80, 0,   32'h0,         4'b0000);
    run("bload_u",     0, 0, 1, 0, 16'h0011, 32'h0,        2, 32'h0000_80AA, 2,  3, 32'h0000_0080, 0,   32'h0,         4'b0000);
    run("bload_lane0", 0, 0, 1, 1, 16'h0010, 32'h0,        1, 32'h0000_80AA, 1,  2, 32'h0000_FFAA, 0,   32'h0,         4'b0000);
    run("bstore",      0, 1, 1, 0, 16'h0011, 32'h1234,     2, 32'h0000_FFFF, 2,  3, 32'h0,         0,   32'h0000_3434, 4'b0010);
    run("wstore",      0, 1, 0, 0, 16'h0020, 32'hA5C3,     1, 32'h0000_FFFF, 1,  2, 32'h0,         0,   32'h0000_A5C3, 4'b0011);
    run("misalign",    0, 1, 0, 0, 16'h0013, 32'h5678,     1, 32'h0,         0,  1, 32'h0,         1,   32'h0,         4'b0000);
    run("timeout",     0, 0, 0, 0, 16'h0040, 32'h0,        0, 32'h0000_1111, 4,  5, 32'h0,         2,   32'h0,         4'b0000);
    run("tmo_resp_win",0, 0, 0, 0, 16'h0040, 32'h0,        4, 32'h0000_2222, 4,  5, 32'h0000_2222, 0,   32'h0,         4'b0000);
    run("w32_bload_s", 1, 0, 1, 1, 16'h0013, 32'h0,        1, 32'h80AA_5511, 1,  2, 32'hFFFF_FF80, 0,   32'h0,         4'b0000);
    run("w32_bload_u", 1, 0, 1, 0, 16'h0013, 32'h0,        2, 32'h80AA_5511, 2,  3, 32'h0000_0080, 0,   32'h0,         4'b0000);
    run("w32_bstore",  1, 1, 1, 0, 16'h0013, 32'h1234,     3, 32'h0,         3,  4, 32'h0,         0,   32'h3434_3434, 4'b1000);
    run("w32_wload",   1, 0, 0, 0, 16'h0014, 32'h0,        2, 32'hCAFE_F00D, 2,  3, 32'hCAFE_F00D, 0,   32'h0,         4'b0000);
    run("w32_misalign",1, 0, 0, 0, 16'h0012, 32'h0,        1, 32'h0,         0,  1, 32'h0,         1,   32'h0,         4'b0000);

    // Stray mem_resp while idle must not produce a response
    @(negedge clk);
    mresp[0] = 1'b1;
    @(posedge clk); #1;
    mresp[0] = 1'b0;
    check("idle_resp.no_valid", 32'(o_rvalid[0]), 32'd0);
    @(posedge clk); #1;
    check("idle_resp.no_valid2", 32'(o_rvalid[0]), 32'd0);
    check("idle_resp.ready", 32'(o_ready[0]), 32'd1);

    // Reset during the second strobe cycle aborts the request silently
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b0; rs[0] = 1'b0; raddr[0] = 16'h0030;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    check("rst.c1_read", 32'(o_read[0]), 32'd1);
    @(posedge clk); #1;
    check("rst.c2_read", 32'(o_read[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst.read_drop", 32'(o_read[0]), 32'd0);
    check("rst.ready_async", 32'(o_ready[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_rvalid[0]) seen = 1'b1;
    end
    check("rst.no_resp", 32'(seen), 32'd0);
    check("rst.ready_after", 32'(o_ready[0]), 32'd1);
    check("rst.strobes_idle", 32'({o_read[0], o_write[0]}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
